actmap_reader: RTL and testbench
================================

ACTMAP_READER -- requirements
Module: actmap_reader

Interface
REQ-001 SHALL have parameters: DATA_WIDTH, default 8, element width; PE_SIZE, default 14, elements per row; MEM0_DEPTH, default 4116, BRAM rows; MEM0_ADDR_WIDTH, default 13, BRAM address width; MEM0_DATA_WIDTH, default 112 (PE_SIZE*DATA_WIDTH), BRAM word width.
REQ-002 SHALL use one clock, with reset synchronous and active-high.
REQ-003 SHALL have ports: clk  in  1  clock; rst  in  1  synchronous active-high reset.
REQ-004 SHALL have ports: start_i  in  1  start pulse; base_addr_i  in  MEM0_ADDR_WIDTH  first row address; len_i  in  MEM0_ADDR_WIDTH  rows to read.
REQ-005 SHALL have ports: busy_o  out  1  transfer active; done_o  out  1  one-cycle completion pulse.
REQ-006 SHALL have BRAM ports: mem0_addr0  out  MEM0_ADDR_WIDTH; mem0_ce0  out  1; mem0_we0  out  1, tied 0; mem0_q0  in  MEM0_DATA_WIDTH, read data valid one cycle after mem0_ce0.
REQ-007 SHALL have stream ports: row_o  out  MEM0_DATA_WIDTH  activation row to SA ifmap path; row_valid_o  out  1; row_ready_i  in  1.

Function
REQ-008 SHALL read back activation rows written by the SA data mover and stream them in address order as SA ifmap rows.
REQ-009 SHALL implement FSM states IDLE, READ, DRAIN, DONE.
REQ-010 IDLE: start_i=1 SHALL latch base_addr_i and len_i, clear counters, and go to READ; if len_i=0, SHALL go to DONE instead.
REQ-011 READ: SHALL issue a read (mem0_ce0=1) when issued<len and (fifo_count + inflight - pop) < 2, where pop = row_valid_o & row_ready_i; each issued read increments the address by 1.
REQ-012 The address SHALL wrap from MEM0_DEPTH-1 to 0.
REQ-013 READ SHALL go to DRAIN in the cycle after the last read is issued; DRAIN SHALL go to DONE when all len rows have been popped.
REQ-014 DONE SHALL assert done_o for exactly one cycle, then return to IDLE.
REQ-015 busy_o SHALL be 1 in READ, DRAIN, and DONE.
REQ-016 start_i SHALL be ignored while busy_o=1.
REQ-017 mem0_q0 SHALL be written into a 2-entry FIFO on the clock edge that ends the cycle after the corresponding mem0_ce0; the FIFO SHALL never overflow.
REQ-018 row_o/row_valid_o SHALL present the FIFO head; valid SHALL be 1 iff fifo_count>0.
REQ-019 row_o SHALL remain stable while row_valid_o=1 and row_ready_i=0.
REQ-020 A simultaneous push and pop SHALL leave fifo_count unchanged.
REQ-021 Latency: with start_i sampled at edge E0, mem0_ce0 SHALL be 1 during cycle 1 and row_valid_o SHALL first be 1 in cycle 3.
REQ-022 With row_ready_i held 1, SHALL sustain one row per cycle.
REQ-023 mem0_addr0 SHALL hold its last value while mem0_ce0=0.

Reset
REQ-024 rst=1 SHALL, at any time including mid-transfer, force IDLE, empty the FIFO, clear inflight and counters, and drive busy_o=0, done_o=0, row_valid_o=0, mem0_ce0=0, mem0_we0=0, mem0_addr0=0, and row_o=0.
REQ-025 A read in flight at reset SHALL be discarded.

Structure
REQ-026 The default widths and depths and the FSM state encoding SHALL reside in the shared GEMM package, next to the MEM0 constants used by the data mover.
REQ-027 SHALL instantiate exactly one sub-module, row_skid_fifo: a 2-entry, MEM0_DATA_WIDTH-wide FIFO with count output.

Verification
REQ-028 Scenario: base=0, len=4, row_ready_i=1 -> addresses 0,1,2,3 on consecutive cycles 1-4; rows valid in cycles 3-6 in order; done_o=1 in cycle 7.
REQ-029 Scenario: len=4, row_ready_i toggles 1,0 -> every row delivered exactly once in order; no FIFO overflow; row_o stable during stall cycles.
REQ-030 Scenario: base=4114, len=4 -> addresses 4114, 4115, 0, 1.
REQ-031 Scenario: len=0 -> no mem0_ce0; done_o pulses one cycle after start_i; busy_o returns to 0.
REQ-032 Scenario: rst=1 after 2 rows popped of len=8 -> all outputs zero next cycle; a new start with base=10, len=2 then reads 10, 11 with no stale rows.
REQ-033 Scenario: start_i pulsed while busy_o=1 -> ignored; latched base and len unchanged; mem0_we0 stays 0 throughout.

Source files
------------

// File: rtl/actmap_reader_pkg.sv
// Shared GEMM constants: MEM0 activation BRAM geometry used by the data mover
// and the activation-map reader, plus the reader FSM state encoding.
package actmap_reader_pkg;

    localparam int DEF_DATA_WIDTH      = 8;
    localparam int DEF_PE_SIZE         = 14;
    localparam int DEF_MEM0_DEPTH      = 4116;
    localparam int DEF_MEM0_ADDR_WIDTH = 13;
    localparam int DEF_MEM0_DATA_WIDTH = DEF_PE_SIZE * DEF_DATA_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/actmap_reader_row_skid_fifo.sv
// Two-entry row FIFO between the BRAM read port and the SA ifmap stream.
module row_skid_fifo #(
    parameter int WIDTH = 112
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] data,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is dropped; the reader's issue rule never produces one.
    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && (count != 2'd2);
    assign data    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/actmap_reader.sv
// Reads len activation rows from MEM0 starting at base (wrapping at depth)
// and streams them in address order over a valid/ready row interface.
module actmap_reader
    import actmap_reader_pkg::*;
#(
    parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter int PE_SIZE         = DEF_PE_SIZE,
    parameter int MEM0_DEPTH      = DEF_MEM0_DEPTH,
    parameter int MEM0_ADDR_WIDTH = DEF_MEM0_ADDR_WIDTH,
    parameter int MEM0_DATA_WIDTH = PE_SIZE * DATA_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start_i,
    input  logic [MEM0_ADDR_WIDTH-1:0] base_addr_i,
    input  logic [MEM0_ADDR_WIDTH-1:0] len_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic [MEM0_ADDR_WIDTH-1:0] mem0_addr0,
    output logic                       mem0_ce0,
    output logic                       mem0_we0,
    input  logic [MEM0_DATA_WIDTH-1:0] mem0_q0,
    output logic [MEM0_DATA_WIDTH-1:0] row_o,
    output logic                       row_valid_o,
    input  logic                       row_ready_i,
    output logic [1:0]                 dbg_state
);

    localparam int AW = MEM0_ADDR_WIDTH;

    // Stream handshake: a row transfers in every cycle where row_valid_o and
    // row_ready_i are both 1; row_o is held while valid is 1 and ready is 0.

    state_t          state_q, state_d;
    logic [AW-1:0]   len_q;
    logic [AW-1:0]   issued_q;
    logic [AW-1:0]   popped_q;
    logic [AW-1:0]   next_addr_q;
    logic [AW-1:0]   last_addr_q;
    logic            inflight_q;
    logic [1:0]      fifo_count;
    logic            pop;
    logic            issue;
    logic [2:0]      occupancy;

    assign pop       = row_valid_o & row_ready_i;
    assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_q};
    // Reserve a FIFO slot for every read whose data has not landed yet.
    assign issue     = (state_q == ST_READ) && (issued_q < len_q)
                       && ((occupancy - {2'b00, pop}) < 3'd2);

    assign mem0_ce0    = issue;
    assign mem0_we0    = 1'b0;
    assign mem0_addr0  = issue ? next_addr_q : last_addr_q;
    assign row_valid_o = (fifo_count != 2'd0);
    assign dbg_state   = state_q;

    always_comb begin
        state_d = state_q;
        done_o  = 1'b0;
        busy_o  = (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = (len_i == '0) ? ST_DONE : ST_READ;
                end
            end
            ST_READ: begin
                if (issue && ((issued_q + AW'(1)) == len_q)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if ((popped_q + AW'(pop)) == len_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done_o  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            issued_q    <= '0;
            popped_q    <= '0;
            next_addr_q <= '0;
            last_addr_q <= '0;
            inflight_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= issue;
            if ((state_q == ST_IDLE) && start_i) begin
                len_q       <= len_i;
                next_addr_q <= base_addr_i;
                issued_q    <= '0;
                popped_q    <= '0;
            end
            if (issue) begin
                issued_q    <= issued_q + AW'(1);
                last_addr_q <= next_addr_q;
                next_addr_q <= (next_addr_q == AW'(MEM0_DEPTH - 1)) ? '0
                                                                     : next_addr_q + AW'(1);
            end
            if (pop) begin
                popped_q <= popped_q + AW'(1);
            end
        end
    end

    row_skid_fifo #(
        .WIDTH(MEM0_DATA_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_q),
        .push_data (mem0_q0),
        .pop       (pop),
        .data      (row_o),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_actmap_reader.sv
// Scoreboard bench for actmap_reader: a BRAM model feeds the reader, expected
// addresses/rows are queued per transfer and a monitor checks the stream.
module tb_actmap_reader;

  localparam int AW    = 13;
  localparam int DW    = 112;
  localparam int DEPTH = 4116;
  localparam int W     = 128;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_i = 1'b0;
  logic [AW-1:0] base_addr_i = '0;
  logic [AW-1:0] len_i = '0;
  logic          busy_o, done_o;
  logic [AW-1:0] mem0_addr0;
  logic          mem0_ce0, mem0_we0;
  logic [DW-1:0] mem0_q0 = '0;
  logic [DW-1:0] row_o;
  logic          row_valid_o;
  logic          row_ready_i = 1'b1;
  logic [1:0]    dbg_state;

  actmap_reader dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .base_addr_i (base_addr_i),
    .len_i       (len_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .mem0_addr0  (mem0_addr0),
    .mem0_ce0    (mem0_ce0),
    .mem0_we0    (mem0_we0),
    .mem0_q0     (mem0_q0),
    .row_o       (row_o),
    .row_valid_o (row_valid_o),
    .row_ready_i (row_ready_i),
    .dbg_state   (dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // BRAM model: data valid the cycle after ce
  logic [DW-1:0] mem_model [DEPTH];
  always @(posedge clk) if (mem0_ce0) mem0_q0 <= mem_model[mem0_addr0];

  // scoreboard state
  logic [DW-1:0] exp_q[$];
  logic [AW-1:0] exp_addr_q[$];
  int checks = 0;
  int errors = 0;
  int start_cyc = 0;
  int first_ce_k, last_ce_k, ce_cnt, first_valid_k, done_k, pop_cnt;
  bit done_seen;
  int ready_mode = 0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // reference model: len consecutive rows from base, modulo BRAM depth
  task automatic expect_xfer(input int base, input int len);
    for (int i = 0; i < len; i++) begin
      int a;
      a = (base + i) % DEPTH;
      exp_addr_q.push_back(AW'(a));
      exp_q.push_back(mem_model[a]);
    end
  endtask

  // ready driver
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       row_ready_i = 1'b1;
        1:       row_ready_i = ~row_ready_i;
        default: row_ready_i = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // monitor
  logic          prev_stall = 1'b0;
  logic          prev_done  = 1'b0;
  logic [DW-1:0] prev_row   = '0;
  always @(negedge clk) begin
    int k;
    k = cyc - start_cyc + 1;
    if (rst) begin
      prev_stall = 1'b0;
      prev_done  = 1'b0;
    end else begin
      chk("we0_zero", W'(mem0_we0), W'(0));
      if (mem0_ce0) begin
        ce_cnt++;
        if (first_ce_k == 0) first_ce_k = k;
        last_ce_k = k;
        if (exp_addr_q.size() == 0) chk("addr_unexpected", W'(1), W'(0));
        else chk("addr", W'(mem0_addr0), W'(exp_addr_q.pop_front()));
      end
      if (prev_stall) begin
        chk("stall_valid", W'(row_valid_o), W'(1));
        chk("stall_row", W'(row_o), W'(prev_row));
      end
      if (row_valid_o && first_valid_k == 0) first_valid_k = k;
      if (row_valid_o && row_ready_i) begin
        pop_cnt++;
        if (exp_q.size() == 0) chk("row_unexpected", W'(1), W'(0));
        else chk("row", W'(row_o), W'(exp_q.pop_front()));
      end
      if (done_o) begin
        done_seen = 1'b1;
        done_k    = k;
        chk("done_single", W'(prev_done), W'(0));
        chk("done_rows_left", W'(exp_q.size()), W'(0));
        chk("done_addrs_left", W'(exp_addr_q.size()), W'(0));
      end
      prev_stall = row_valid_o && !row_ready_i;
      prev_row   = row_o;
      prev_done  = done_o;
    end
  end

  // driver tasks
  task automatic start_xfer(input int base, input int len);
    @(posedge clk);
    #1;
    base_addr_i = AW'(base);
    len_i       = AW'(len);
    start_i     = 1'b1;
    expect_xfer(base, len);
    @(posedge clk);
    #1;
    start_i       = 1'b0;
    start_cyc     = cyc;
    first_ce_k    = 0;
    last_ce_k     = 0;
    ce_cnt        = 0;
    first_valid_k = 0;
    done_k        = 0;
    pop_cnt       = 0;
    done_seen     = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!done_seen && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("done_timeout", W'(done_seen), W'(1));
    chk("busy_after_done", W'(busy_o), W'(0));
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"},  W'(busy_o),      W'(0));
    chk({tag, "_done"},  W'(done_o),      W'(0));
    chk({tag, "_valid"}, W'(row_valid_o), W'(0));
    chk({tag, "_ce"},    W'(mem0_ce0),    W'(0));
    chk({tag, "_we"},    W'(mem0_we0),    W'(0));
    chk({tag, "_addr"},  W'(mem0_addr0),  W'(0));
    chk({tag, "_row"},   W'(row_o),       W'(0));
  endtask

  initial begin
    int n;
    for (int i = 0; i < DEPTH; i++)
      mem_model[i] = DW'({$urandom, $urandom, $urandom, $urandom});

    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst = 1'b0;

    // base 0, len 4, always ready: exact cycle timing
    ready_mode = 0;
    start_xfer(0, 4);
    wait_done(100);
    chk("lat_first_ce", W'(first_ce_k), W'(1));
    chk("lat_last_ce", W'(last_ce_k), W'(4));
    chk("lat_ce_cnt", W'(ce_cnt), W'(4));
    chk("lat_first_valid", W'(first_valid_k), W'(3));
    chk("lat_done", W'(done_k), W'(7));

    // ready toggling 1,0
    ready_mode = 1;
    start_xfer(20, 4);
    wait_done(100);
    chk("toggle_pops", W'(pop_cnt), W'(4));

    // address wrap
    ready_mode = 0;
    start_xfer(4114, 4);
    wait_done(100);
    chk("wrap_ce_cnt", W'(ce_cnt), W'(4));

    // zero length
    start_xfer(5, 0);
    wait_done(20);
    chk("len0_ce_cnt", W'(ce_cnt), W'(0));
    chk("len0_done_k", W'(done_k), W'(1));

    // start while busy is ignored
    ready_mode = 1;
    start_xfer(100, 6);
    repeat (2) @(posedge clk);
    #1;
    base_addr_i = AW'(200);
    len_i       = AW'(3);
    start_i     = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    wait_done(100);
    repeat (5) @(posedge clk);
    #1;
    chk("busy_start_ce_cnt", W'(ce_cnt), W'(6));
    chk("busy_start_pops", W'(pop_cnt), W'(6));

    // reset mid-transfer
    ready_mode = 0;
    start_xfer(30, 8);
    n = 0;
    while (pop_cnt < 2 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("midrst_pops_timeout", W'(pop_cnt >= 2), W'(1));
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_idle_outputs("midrst");
    exp_q.delete();
    exp_addr_q.delete();
    rst = 1'b0;
    start_xfer(10, 2);
    wait_done(100);
    chk("post_rst_ce_cnt", W'(ce_cnt), W'(2));
    chk("post_rst_pops", W'(pop_cnt), W'(2));

    // randomized transfers
    for (int t = 0; t < 12; t++) begin
      int b, l;
      ready_mode = 2;
      b = $urandom_range(0, DEPTH - 1);
      l = $urandom_range(0, 12);
      start_xfer(b, l);
      wait_done(400);
      chk("rand_pops", W'(pop_cnt), W'(l));
    end

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
